// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle sequencer for the accumulator CPU.
// Walks FETCH -> DECODE -> (MEM) -> EXEC -> WB with variable-latency
// instruction/data memory handshakes, a resumable HALTED state and a
// wrapping retired-instruction counter.
//
// Optional feature macro: CTRL_TIMEOUT_EN
//   defined   : an 8-bit wait counter bounds every FETCH/MEM wait; reaching
//               TIMEOUT without an acknowledge enters ERROR (bus_err sticky,
//               cleared only by rst).
//   undefined : waits are unbounded, bus_err is tied low, ERROR unreachable.
//
// Handshake rules: ins_req (FETCH) and da_req/da_we (MEM) are raised on
// entry to the state and held unchanged until the matching acknowledge
// (ins_valid / da_valid) is seen high on a rising edge; acknowledges seen
// in any other state are ignored, and a request is never withdrawn early.
module multicycle_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             is_zero,
  input  logic             ins_valid,
  input  logic             da_valid,
  input  logic             resume,
  output logic             ins_req,
  output logic             da_req,
  output logic             da_we,
  output logic             acc_load,
  output logic [1:0]       acc_op,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             pc_skip,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_ERROR  = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Reject an out-of-range watchdog limit at elaboration time.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("multicycle_ctrl: TIMEOUT must be within 1..255");
  end

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               skip_q, skip_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               is_data_op;

  // Data ops (ADD..STO) are the only ones that visit MEM.
  assign is_data_op = (op_q >= OP_ADD) && (op_q <= OP_STO);

`ifdef CTRL_TIMEOUT_EN
  localparam logic [8:0] WD_LIMIT = 9'(TIMEOUT);
  logic [7:0] wd_q, wd_d;
  logic [8:0] wd_inc;
  logic       bus_err_q, bus_err_d;
  logic       waiting;

  assign wd_inc  = {1'b0, wd_q} + 9'd1;
  // A cycle counts as a wait only when the acknowledge for the current
  // request is absent; an acknowledge in the limit cycle still wins.
  assign waiting = ((state_q == S_FETCH) && !ins_valid) ||
                   ((state_q == S_MEM)   && !da_valid);
`endif

  // State, latched opcode, skip flag, retire count (and watchdog) registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 3'd0;
      skip_q    <= 1'b0;
      retired_q <= '0;
`ifdef CTRL_TIMEOUT_EN
      wd_q      <= 8'd0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      skip_q    <= skip_d;
      retired_q <= retired_d;
`ifdef CTRL_TIMEOUT_EN
      wd_q      <= wd_d;
      bus_err_q <= bus_err_d;
`endif
    end
  end

  // Next-state logic: sequencing, opcode capture, skip and retire updates.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    skip_d    = skip_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        if (ins_valid) begin
          op_d    = opcode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_data_op ? S_MEM : S_EXEC;
      S_MEM: begin
        if (da_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_SKZ) skip_d = is_zero;
        state_d = (op_q == OP_HLT) ? S_HALTED : S_WB;
      end
      S_WB: begin
        retired_d = retired_q + 1'b1;
        skip_d    = 1'b0;
        state_d   = S_FETCH;
      end
      S_HALTED: begin
        if (resume) state_d = S_WB;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_FETCH;
    endcase
`ifdef CTRL_TIMEOUT_EN
    if (waiting && (wd_inc == WD_LIMIT)) state_d = S_ERROR;
`endif
  end

`ifdef CTRL_TIMEOUT_EN
  // Watchdog: restart on entry to a wait state, count unacknowledged cycles.
  always_comb begin
    wd_d      = wd_q;
    bus_err_d = bus_err_q;
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wd_d = 8'd0;
    end else if (waiting) begin
      wd_d = wd_inc[7:0];
    end
    if (state_d == S_ERROR) bus_err_d = 1'b1;
  end
`endif

  // Moore output decode from state and latched opcode; all zero during rst.
  always_comb begin
    ins_req  = 1'b0;
    da_req   = 1'b0;
    da_we    = 1'b0;
    acc_load = 1'b0;
    acc_op   = 2'b00;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_skip  = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: ins_req = 1'b1;
        S_MEM: begin
          da_req = 1'b1;
          da_we  = (op_q == OP_STO);
        end
        S_EXEC: begin
          if ((op_q >= OP_ADD) && (op_q <= OP_LDA)) begin
            acc_load = 1'b1;
            acc_op   = op_q[1:0] - 2'd2;
          end
          if (op_q == OP_JMP) pc_load = 1'b1;
        end
        S_WB: begin
          pc_inc  = (op_q != OP_JMP);
          pc_skip = (op_q != OP_JMP) && skip_q;
        end
        S_HALTED: halted = 1'b1;
        S_ERROR:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign retired = retired_q;
  assign state_o = state_q;

`ifdef CTRL_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Each instruction is described by its opcode,
// fetch/data wait counts and zero flag; the bench expands that description
// into the per-cycle output trace it must see and drives matching inputs.
// Build with +define+CTRL_TIMEOUT_EN to include the watchdog scenario.
module tb_multicycle_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int VW      = 14 + CNT_W;

  logic             clk;
  logic             rst;
  logic [2:0]       opcode;
  logic             is_zero;
  logic             ins_valid;
  logic             da_valid;
  logic             resume;
  logic             ins_req;
  logic             da_req;
  logic             da_we;
  logic             acc_load;
  logic [1:0]       acc_op;
  logic             pc_load;
  logic             pc_inc;
  logic             pc_skip;
  logic             halted;
  logic             bus_err;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_o;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero),
    .ins_valid(ins_valid), .da_valid(da_valid), .resume(resume),
    .ins_req(ins_req), .da_req(da_req), .da_we(da_we),
    .acc_load(acc_load), .acc_op(acc_op), .pc_load(pc_load),
    .pc_inc(pc_inc), .pc_skip(pc_skip), .halted(halted),
    .bus_err(bus_err), .retired(retired), .state_o(state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [VW-1:0]    exp_q[$];
  logic [CNT_W-1:0] ret_m;
  int               n_checks;
  int               n_pass;

  function automatic logic [VW-1:0] mk(input logic [2:0] st, input logic ir,
      input logic dr, input logic dw, input logic al, input logic [1:0] ao,
      input logic pl, input logic pi, input logic ps, input logic h,
      input logic be, input logic [CNT_W-1:0] rt);
    return {st, ir, dr, dw, al, ao, pl, pi, ps, h, be, rt};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
  endtask

  // Compare process: one expected output vector per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [VW-1:0] e;
      e = exp_q.pop_front();
      check("cycle_outputs",
            32'({state_o, ins_req, da_req, da_we, acc_load, acc_op, pc_load,
                 pc_inc, pc_skip, halted, bus_err, retired}), 32'(e));
    end
  end

  // Driver: one clock cycle with given inputs and the outputs expected in it.
  task automatic step(input logic iv, input logic dv, input logic rs,
                      input logic iz, input logic [2:0] opc, input logic [VW-1:0] e);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ins_valid = iv;
    da_valid  = dv;
    resume    = rs;
    is_zero   = iz;
    opcode    = opc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst       = 1'b1;
      ins_valid = 1'($urandom_range(0, 1));
      da_valid  = 1'($urandom_range(0, 1));
      resume    = 1'b1;
      exp_q.push_back('0);
    end
    ret_m = '0;
  endtask

  // Expand one instruction into its cycle trace. Acknowledges and resume
  // are randomly asserted in cycles where they must be ignored.
  task automatic run_instr(input logic [2:0] op, input int fw, input int mw,
                           input logic z, input int hc, output int ncyc);
    logic n;
    logic data_op;
    logic [2:0] nop;
    data_op = (op >= 3'd2) && (op <= 3'd6);
    nop     = ~op;
    ncyc    = 0;
    for (int i = 0; i <= fw; i++) begin
      n = 1'($urandom_range(0, 1));
      step(i == fw, n, n, ~z, (i == fw) ? op : nop,
           mk(3'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, ret_m));
      ncyc++;
    end
    n = 1'($urandom_range(0, 1));
    step(n, n, n, ~z, nop, mk(3'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, ret_m));
    ncyc++;
    if (data_op) begin
      for (int i = 0; i <= mw; i++) begin
        n = 1'($urandom_range(0, 1));
        step(n, i == mw, n, ~z, nop,
             mk(3'd2, 0, 1, op == 3'd6, 0, 2'd0, 0, 0, 0, 0, 0, ret_m));
        ncyc++;
      end
    end
    n = 1'($urandom_range(0, 1));
    step(n, n, n, z, nop,
         mk(3'd3, 0, 0, 0, (op >= 3'd2 && op <= 3'd5),
            (op >= 3'd2 && op <= 3'd5) ? 2'(op - 3'd2) : 2'd0,
            op == 3'd7, 0, 0, 0, 0, ret_m));
    ncyc++;
    if (op == 3'd0) begin
      for (int i = 0; i <= hc; i++) begin
        n = 1'($urandom_range(0, 1));
        step(n, n, i == hc, ~z, nop, mk(3'd5, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0, ret_m));
        ncyc++;
      end
    end
    n = 1'($urandom_range(0, 1));
    step(n, n, n, ~z, nop,
         mk(3'd4, 0, 0, 0, 0, 2'd0, 0, op != 3'd7, (op == 3'd1) && z, 0, 0, ret_m));
    ncyc++;
    ret_m = ret_m + 1'b1;
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    n_checks++;
    $display("FAIL run_timeout: simulation did not finish within time limit");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int nc;
    n_checks  = 0;
    n_pass    = 0;
    ret_m     = '0;
    rst       = 1'b1;
    opcode    = 3'd0;
    is_zero   = 1'b0;
    ins_valid = 1'b0;
    da_valid  = 1'b0;
    resume    = 1'b0;

    do_reset(3);

    // Zero-wait ADD: 5 cycles, retire count 0 -> 1.
    run_instr(3'd2, 0, 0, 0, 0, nc);
    check("add_cycles", 32'(nc), 32'd5);
    @(negedge clk);
    check("add_wb_state", 32'(state_o), 32'd4);
    check("add_wb_pc_inc", 32'(pc_inc), 32'd1);
    check("add_wb_retired_before", 32'(retired), 32'd0);

    // STO with data ack delayed 3 cycles: 8 cycles total.
    run_instr(3'd6, 0, 3, 0, 0, nc);
    check("sto_cycles", 32'(nc), 32'd8);
    @(negedge clk);
    check("sto_wb_retired_before", 32'(retired), 32'd1);

    run_instr(3'd5, 2, 1, 0, 0, nc);
    run_instr(3'd4, 1, 0, 1, 0, nc);
    run_instr(3'd3, 0, 2, 0, 0, nc);

    // SKZ taken / not taken, JMP.
    run_instr(3'd1, 0, 0, 1, 0, nc);
    check("skz_cycles", 32'(nc), 32'd4);
    @(negedge clk);
    check("skz_taken_pc_skip", 32'(pc_skip), 32'd1);
    run_instr(3'd1, 1, 0, 0, 0, nc);
    @(negedge clk);
    check("skz_not_taken_pc_skip", 32'(pc_skip), 32'd0);
    run_instr(3'd7, 0, 0, 0, 0, nc);
    check("jmp_cycles", 32'(nc), 32'd4);
    @(negedge clk);
    check("jmp_wb_pc_inc", 32'(pc_inc), 32'd0);

    // HLT held 10 cycles then resumed.
    run_instr(3'd0, 0, 0, 0, 10, nc);
    @(negedge clk);
    check("hlt_wb_pc_inc", 32'(pc_inc), 32'd1);
    check("hlt_wb_retired_before", 32'(retired), 32'd8);

    // Reset during a data wait abandons the instruction.
    step(1, 0, 0, 0, 3'd2, mk(3'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, ret_m));
    step(0, 0, 0, 0, 3'd0, mk(3'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, ret_m));
    step(0, 0, 0, 0, 3'd0, mk(3'd2, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, ret_m));
    step(0, 0, 0, 0, 3'd0, mk(3'd2, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, ret_m));
    do_reset(2);
    @(negedge clk);
    check("mid_reset_retired", 32'(retired), 32'd0);
    check("mid_reset_ins_req", 32'(ins_req), 32'd0);

    // Retire counter wraps after 2^CNT_W instructions.
    for (int i = 0; i < 16; i++) run_instr(3'd7, 0, 0, 0, 0, nc);
    @(negedge clk);
    check("wrap_wb_retired_before", 32'(retired), 32'd15);
    run_instr(3'd2, 0, 0, 0, 0, nc);
    @(negedge clk);
    check("wrap_after_retired", 32'(retired), 32'd0);

`ifdef CTRL_TIMEOUT_EN
    // Fetch never acknowledged: ERROR after TIMEOUT fetch cycles, sticky.
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 0, 3'd2, mk(3'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, ret_m));
    for (int i = 0; i < 5; i++)
      step(1, 1, 1, 0, 3'd2, mk(3'd6, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 1, ret_m));
    @(negedge clk);
    check("timeout_bus_err", 32'(bus_err), 32'd1);
    do_reset(2);
    // Acknowledge in the limit cycle wins.
    run_instr(3'd2, 3, 3, 0, 0, nc);
    check("limit_ack_cycles", 32'(nc), 32'd11);
`endif

    step(0, 0, 0, 0, 3'd0, mk(3'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, ret_m));
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the accumulator CPU: the next generation of the fixed four-state fetch/decode/execute/writeback sequencer. It adds variable-latency instruction and data memory handshakes, a resumable halt, a retired-instruction counter, and an optional bus watchdog. It sits between the instruction register/opcode decode path and the PC, accumulator and memory enables.

## Interface
- CNT_W, 16, width of retired-instruction counter
- TIMEOUT, 15, watchdog limit in wait cycles (used only with CTRL_TIMEOUT_EN); legal 1..255
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- opcode  in  3  instruction opcode; valid while ins_valid high
- is_zero  in  1  accumulator-zero flag
- ins_valid  in  1  instruction memory acknowledge
- da_valid  in  1  data memory acknowledge (read data valid / write done)
- resume  in  1  restart from HALTED
- ins_req  out  1  instruction fetch request
- da_req  out  1  data memory request
- da_we  out  1  data memory write enable; qualifies da_req
- acc_load  out  1  accumulator load strobe
- acc_op  out  2  00 ADD, 01 AND, 10 XOR, 11 pass (LDA)
- pc_load  out  1  load PC from operand (JMP)
- pc_inc  out  1  PC increment strobe
- pc_skip  out  1  with pc_inc, increment by 2
- halted  out  1  in HALTED or ERROR
- bus_err  out  1  sticky watchdog error
- retired  out  CNT_W  retired-instruction count
- state_o  out  3  current state encoding

## Operation
- ISA: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP. Data ops: 2..6.
- States (state_o): FETCH=0, DECODE=1, MEM=2, EXEC=3, WB=4, HALTED=5, ERROR=6; 7 unused, recovers to FETCH.
- FETCH: ins_req=1; hold until ins_valid, then latch opcode into op_q -> DECODE.
- DECODE: one cycle; data op -> MEM, else -> EXEC.
- MEM: da_req=1, da_we=(op_q==6); hold until da_valid -> EXEC.
- EXEC: ops 2..5 acc_load=1, acc_op=op_q-2; JMP pc_load=1; SKZ registers skip_q=is_zero; HLT -> HALTED; all others -> WB.
- WB: pc_inc=1 unless op_q==JMP; pc_skip=skip_q; retired+1 (wraps mod 2^CNT_W); skip_q cleared -> FETCH.
- HALTED: halted=1, all strobes 0; resume -> WB (PC advances past HLT; HLT retires). resume outside HALTED ignored.
- ERROR: halted=1, bus_err=1; exit only via rst.
- All outputs Moore-decoded from state and op_q; only the listed outputs are nonzero in each state.

## Timing
- rst asserted: state=FETCH, op_q=0, skip_q=0, retired=0, wd counter=0, bus_err=0; all outputs forced 0 while rst high, including ins_req.
- First ins_req: first cycle after rst deasserts.
- ins_valid/da_valid sampled only in FETCH/MEM respectively; acknowledges in other states are ignored.
- Zero-wait latency: data op 5 cycles (FETCH, DECODE, MEM, EXEC, WB); SKZ/JMP 4 cycles; each wait cycle adds 1.
- Requests stay high, with stable da_we, until acknowledged; no early withdrawal.
- Reset mid-operation abandons the instruction; retired is not incremented.
- resume and rst together: rst wins.

## Configuration
- CTRL_TIMEOUT_EN defined: an 8-bit wait counter clears on entry to FETCH/MEM and increments on each FETCH/MEM cycle without an acknowledge. When it reaches TIMEOUT with no acknowledge in that cycle -> ERROR, bus_err sticky. An acknowledge in the same cycle wins.
- Undefined: waits are unbounded, bus_err tied 0, ERROR unreachable, counter not built.

## Test plan
- Zero-wait ADD (op 2), ins_valid/da_valid high immediately -> state_o 0,1,2,3,4; acc_load=1, acc_op=00 in EXEC; pc_inc in WB; retired 0->1.
- STO with da_valid delayed 3 cycles -> da_req=da_we=1 for 4 cycles; instruction takes 8 cycles; no acc_load.
- SKZ with is_zero=1 in EXEC -> WB pc_inc=1, pc_skip=1; is_zero=0 -> pc_skip=0. JMP -> pc_load in EXEC, pc_inc=0 in WB.
- HLT -> halted=1, stays 10 cycles; resume pulse -> WB, pc_inc=1, retired+1, then FETCH.
- CTRL_TIMEOUT_EN, TIMEOUT=4, ins_valid never asserted -> ERROR after 4 FETCH cycles, bus_err=1 and held until rst; ins_valid in 4th cycle -> DECODE, no error.
- rst asserted during MEM wait -> all outputs 0, retired=0, FETCH with ins_req=1 one cycle after release; retired at 2^CNT_W-1 wraps to 0 on next WB.
